wisc_pipe_ctrl: RTL and testbench

Pipelined control unit for the WISC-15 core: decodes the 4-bit opcode in ID and carries the control bundle through EX, MEM and WB, with per-stage valid bits. Adds what the single-cycle decoder lacks: load-use interlock, taken-branch flush, halt drain and illegal-opcode detection. Sits between the IF/ID register and the datapath stage muxes; every control field defaults to 0 for bubbles.

---
 rtl/wisc_pkg.sv | 48 ++++
 rtl/wisc_decode.sv | 46 ++++
 rtl/wisc_pipe_ctrl.sv | 99 +++++++++
 tb/tb_wisc_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-15 pipeline control: opcodes, ALU commands
// and the per-stage control bundle.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_PADDSB = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_NAND   = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_SRL    = 4'h6;
    localparam logic [3:0] OP_SRA    = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_CALL   = 4'hD;
    localparam logic [3:0] OP_RET    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PADDSB = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_NAND   = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b1100;
    localparam logic [3:0] ALU_SRL    = 4'b1110;
    localparam logic [3:0] ALU_SRA    = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_cmd;
        logic       alu_src;
        logic       reg_wrt;
        logic       mem_to_reg;
        logic       mem_wrt;
        logic       branch;
        logic       call;
        logic       ret;
        logic       halt;
        logic       set_over;
        logic       set_zero;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/wisc_decode.sv
// Combinational opcode decoder: control bundle, source-register usage and
// illegal-opcode detection.
module wisc_decode
    import wisc_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl,
    output logic            uses_rs,
    output logic            uses_rt,
    output logic            illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = (opcode >> 4) != '0;
        if (!illegal) begin
            case (opcode[3:0])
                OP_ADD:    begin ctrl.reg_wrt = 1'b1; ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_cmd = ALU_ADD; end
                OP_PADDSB: begin ctrl.reg_wrt = 1'b1; ctrl.alu_cmd = ALU_PADDSB; end
                OP_SUB:    begin ctrl.reg_wrt = 1'b1; ctrl.set_over = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_cmd = ALU_SUB; end
                OP_NAND:   begin ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_cmd = ALU_NAND; end
                OP_XOR:    begin ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_cmd = ALU_XOR; end
                OP_SLL:    begin ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_cmd = ALU_SLL; end
                OP_SRL:    begin ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_cmd = ALU_SRL; end
                OP_SRA:    begin ctrl.reg_wrt = 1'b1; ctrl.set_zero = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_cmd = ALU_SRA; end
                OP_LW:     begin ctrl.reg_wrt = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1; end
                OP_SW:     begin ctrl.mem_wrt = 1'b1; ctrl.alu_src = 1'b1; end
                OP_LHB:    ctrl.reg_wrt = 1'b1;
                OP_LLB:    ctrl.reg_wrt = 1'b1;
                OP_B:      ctrl.branch = 1'b1;
                OP_CALL:   begin ctrl.reg_wrt = 1'b1; ctrl.call = 1'b1; ctrl.branch = 1'b1; end
                OP_RET:    begin ctrl.ret = 1'b1; ctrl.branch = 1'b1; end
                OP_HLT:    ctrl.halt = 1'b1;
                default:   ctrl = CTRL_NOP;
            endcase
            // Ops 0-4 and SW read both sources; 5-8, LHB and RET read rs only.
            uses_rs = (opcode[3:0] <= OP_SW) || (opcode[3:0] == OP_LHB) || (opcode[3:0] == OP_RET);
            uses_rt = (opcode[3:0] <= OP_XOR) || (opcode[3:0] == OP_SW);
        end
    end

endmodule

// File: rtl/wisc_pipe_ctrl.sv
// WISC-15 pipelined control: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers with load-use interlock, branch flush, halt drain and sticky flags.
module wisc_pipe_ctrl
    import wisc_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int RA_W     = 4,
    parameter bit STALL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              ex_cond_true,
    output logic              stall,
    output logic              flush,
    output logic              pc_hold,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [RA_W-1:0]   ex_rd,
    output logic [RA_W-1:0]   mem_rd,
    output logic [RA_W-1:0]   wb_rd,
    output logic              illegal,
    output logic              halted
);

    ctrl_t            dec_ctrl;
    logic             dec_rs, dec_rt, dec_ill;
    ctrl_t            ex_q, mem_q, wb_q;
    logic             ex_v, mem_v, wb_v;
    logic [RA_W-1:0]  ex_rd_q, mem_rd_q, wb_rd_q;
    logic             hold_q, ill_q, halt_q;
    logic             id_live, taken, load_use, accept, issue;

    wisc_decode #(.OP_W(OP_W)) u_decode (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .uses_rs (dec_rs),
        .uses_rt (dec_rt),
        .illegal (dec_ill)
    );

    always_comb begin
        id_live  = id_valid & ~hold_q;
        taken    = ex_v & (ex_q.call | ex_q.ret | (ex_q.branch & ex_cond_true));
        load_use = STALL_EN & ex_v & ex_q.mem_to_reg & ex_q.reg_wrt & id_live &
                   ((dec_rs && (ex_rd_q == id_rs)) || (dec_rt && (ex_rd_q == id_rt)));
        // A taken branch discards ID, so any interlock on it is moot.
        stall    = load_use & ~taken;
        flush    = taken;
        accept   = id_live & ~stall & ~taken;
        issue    = accept & ~dec_ill;
        pc_hold  = hold_q | (issue & dec_ctrl.halt);
        halted   = halt_q | (wb_v & wb_q.halt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v     <= 1'b0;
            mem_v    <= 1'b0;
            wb_v     <= 1'b0;
            ex_q     <= CTRL_NOP;
            mem_q    <= CTRL_NOP;
            wb_q     <= CTRL_NOP;
            ex_rd_q  <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
            hold_q   <= 1'b0;
            ill_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            ex_v     <= issue;
            ex_q     <= issue ? dec_ctrl : CTRL_NOP;
            ex_rd_q  <= issue ? id_rd : '0;
            mem_v    <= ex_v;
            mem_q    <= ex_q;
            mem_rd_q <= ex_rd_q;
            wb_v     <= mem_v;
            wb_q     <= mem_q;
            wb_rd_q  <= mem_rd_q;
            hold_q   <= pc_hold;
            ill_q    <= ill_q | (accept & dec_ill);
            halt_q   <= halted;
        end
    end

    assign ex_ctrl  = ex_q;
    assign mem_ctrl = mem_q;
    assign wb_ctrl  = wb_q;
    assign ex_rd    = ex_rd_q;
    assign mem_rd   = mem_rd_q;
    assign wb_rd    = wb_rd_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_wisc_pipe_ctrl.sv
// Directed bench for wisc_pipe_ctrl: default instance plus an OP_W=5,
// STALL_EN=0 instance; WB results are checked through a scoreboard queue.
module tb_wisc_pipe_ctrl;
    import wisc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_valid2;
    logic [3:0]        id_opcode;
    logic [4:0]        id_opcode2;
    logic [3:0]        id_rd, id_rs, id_rt;
    logic              ex_cond_true;

    logic              stall, flush, pc_hold, illegal, halted;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [3:0]        ex_rd, mem_rd, wb_rd;

    logic              stall2, flush2, pc_hold2, illegal2, halted2;
    logic [CTRL_W-1:0] ex_ctrl2, mem_ctrl2, wb_ctrl2;
    logic [3:0]        ex_rd2, mem_rd2, wb_rd2;

    typedef struct {
        ctrl_t       c;
        logic [3:0]  rd;
        int unsigned due;
    } sb_t;

    sb_t         sb[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        hold_m = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wisc_pipe_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .ex_cond_true(ex_cond_true),
        .stall(stall), .flush(flush), .pc_hold(pc_hold),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .illegal(illegal), .halted(halted)
    );

    wisc_pipe_ctrl #(.OP_W(5), .RA_W(4), .STALL_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid2), .id_opcode(id_opcode2),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .ex_cond_true(ex_cond_true),
        .stall(stall2), .flush(flush2), .pc_hold(pc_hold2),
        .ex_ctrl(ex_ctrl2), .mem_ctrl(mem_ctrl2), .wb_ctrl(wb_ctrl2),
        .ex_rd(ex_rd2), .mem_rd(mem_rd2), .wb_rd(wb_rd2),
        .illegal(illegal2), .halted(halted2)
    );

    // Reference decode written directly from the opcode map.
    function automatic ctrl_t ref_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            4'h0: begin c.reg_wrt = 1'b1; c.set_over = 1'b1; c.set_zero = 1'b1; c.alu_cmd = 4'b0000; end
            4'h1: begin c.reg_wrt = 1'b1; c.alu_cmd = 4'b0010; end
            4'h2: begin c.reg_wrt = 1'b1; c.set_over = 1'b1; c.set_zero = 1'b1; c.alu_cmd = 4'b0001; end
            4'h3: begin c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_cmd = 4'b1000; end
            4'h4: begin c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_cmd = 4'b0100; end
            4'h5: begin c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; c.alu_cmd = 4'b1100; end
            4'h6: begin c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; c.alu_cmd = 4'b1110; end
            4'h7: begin c.reg_wrt = 1'b1; c.set_zero = 1'b1; c.alu_src = 1'b1; c.alu_cmd = 4'b1111; end
            4'h8: begin c.reg_wrt = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
            4'h9: begin c.mem_wrt = 1'b1; c.alu_src = 1'b1; end
            4'hA, 4'hB: c.reg_wrt = 1'b1;
            4'hC: c.branch = 1'b1;
            4'hD: begin c.reg_wrt = 1'b1; c.call = 1'b1; c.branch = 1'b1; end
            4'hE: begin c.ret = 1'b1; c.branch = 1'b1; end
            default: c.halt = 1'b1;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ID cycle on the default instance: drive, check hazard outputs
    // before the edge, check EX after it, and queue the expected WB entry.
    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [3:0] rt, input logic cond,
                        input logic e_stall, input logic e_flush);
        logic  acc;
        ctrl_t e;
        sb_t   item;
        id_valid = v; id_valid2 = 1'b0; id_opcode = op; id_opcode2 = {1'b0, op};
        id_rd = rd; id_rs = rs; id_rt = rt; ex_cond_true = cond;
        acc = v & ~e_stall & ~e_flush & ~hold_m;
        if (acc && op == 4'hF) hold_m = 1'b1;
        e = acc ? ref_ctrl(op) : '0;
        #3;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("pc_hold", 32'(pc_hold), 32'(hold_m));
        if (acc) begin
            item.c = e; item.rd = rd; item.due = cyc + 3;
            sb.push_back(item);
        end
        @(posedge clk); #1;
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e));
        chk("ex_rd", 32'(ex_rd), acc ? 32'(rd) : 32'd0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // One ID cycle on the OP_W=5 / STALL_EN=0 instance.
    task automatic step2(input logic v, input logic [4:0] op5, input logic [3:0] rd,
                         input logic [3:0] rs, input logic e_acc);
        logic [3:0] op4;
        op4 = op5[3:0];
        id_valid = 1'b0; id_valid2 = v; id_opcode = op4; id_opcode2 = op5;
        id_rd = rd; id_rs = rs; id_rt = 4'h0; ex_cond_true = 1'b0;
        #3;
        chk("stall2", 32'(stall2), 32'd0);
        @(posedge clk); #1;
        chk("ex_ctrl2", 32'(ex_ctrl2), e_acc ? 32'(ref_ctrl(op4)) : 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b0; id_valid2 = 1'b0; id_opcode = '0; id_opcode2 = '0;
        id_rd = '0; id_rs = '0; id_rt = '0; ex_cond_true = 1'b0;
        @(posedge clk); #1;
        hold_m = 1'b0;
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
        chk("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("rst_rds", 32'({ex_rd, mem_rd, wb_rd}), 32'd0);
        chk("rst_flags", 32'({stall, flush, pc_hold, illegal, halted}), 32'd0);
        chk("rst_flags2", 32'({pc_hold2, illegal2, halted2}), 32'd0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && wb_ctrl != '0) begin
            sb_t x;
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_ctrl), 32'd0);
            end else begin
                x = sb.pop_front();
                chk("wb_ctrl", 32'(wb_ctrl), 32'(x.c));
                chk("wb_rd", 32'(wb_rd), 32'(x.rd));
                chk("wb_cycle", cyc, x.due);
            end
        end
    end

    initial begin
        do_reset();
        do_reset();

        // ADD then SUB, no hazard
        step(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_SUB, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
        chk("mem_ctrl_add", 32'(mem_ctrl), 32'(ref_ctrl(OP_ADD)));
        idle(3);

        // Load-use: one stall cycle, ADD re-presented and issued a cycle late
        step(1'b1, OP_LW,  4'd3, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 4'd6, 4'd3, 4'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, OP_ADD, 4'd6, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
        // LW followed by an rt-only match on SW
        step(1'b1, OP_LW,  4'd9, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_SW,  4'd0, 4'd2, 4'd9, 1'b0, 1'b1, 1'b0);
        step(1'b1, OP_SW,  4'd0, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        // LW followed by LLB naming the same register: no source use, no stall
        step(1'b1, OP_LW,  4'd5, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_LLB, 4'd7, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Branch not taken, then taken
        step(1'b1, OP_B,   4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, OP_B,   4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 4'd2, 4'd1, 4'd1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // RET taken with LW in MEM and a would-be hazard on rs
        step(1'b1, OP_LW,  4'd5, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_RET, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, OP_RET, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 4'd8, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
        idle(3);
        // HLT squashed behind a taken B
        step(1'b1, OP_B,   4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(4);
        chk("flushed_hlt_halted", 32'(halted), 32'd0);

        // Halt drain
        step(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_XOR, 4'd2, 4'd7, 4'd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 4'd9, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        chk("halted_before_wb", 32'(halted), 32'd0);
        idle(1);
        chk("halted_at_wb", 32'(halted), 32'd1);
        idle(2);
        chk("halted_sticky", 32'(halted), 32'd1);
        chk("sb_drained", sb.size(), 32'd0);
        do_reset();

        // Reset mid-stream discards in-flight work
        step(1'b1, OP_SUB, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_LHB, 4'd5, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        sb.delete();
        do_reset();
        idle(3);

        // Second instance: no interlock, wide-opcode illegal detection
        step2(1'b1, {1'b0, OP_LW},  4'd3, 4'd1, 1'b1);
        step2(1'b1, {1'b0, OP_ADD}, 4'd4, 4'd3, 1'b1);
        step2(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
        chk("illegal2_clear", 32'(illegal2), 32'd0);
        step2(1'b1, 5'b10000, 4'd7, 4'd0, 1'b0);
        chk("illegal2_set", 32'(illegal2), 32'd1);
        step2(1'b1, {1'b0, OP_SUB}, 4'd8, 4'd2, 1'b1);
        chk("ex_rd2_after_illegal", 32'(ex_rd2), 32'd8);
        step2(1'b0, 5'b00000, 4'd0, 4'd0, 1'b0);
        chk("illegal2_sticky", 32'(illegal2), 32'd1);
        chk("illegal_other_dut", 32'(illegal), 32'd0);

        chk("sb_empty_end", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
